// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e     : sequencer FSM states (RUN, MEM_WAIT)
//   REG_ADDR_W  : architectural register index width
//   REG_X0      : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    // Writes to x0 are discarded, so a load targeting x0 never creates a hazard.
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use detector. Flags the case where the instruction
// in ID reads a register that the load currently in EX has not yet produced.
// Ports:
//   id_rs1, id_rs2           : source register indices of the ID instruction
//   id_uses_rs1, id_uses_rs2 : ID instruction really reads rs1 / rs2
//   ex_rd                    : destination register of the EX instruction
//   ex_mem_read              : EX instruction is a load
//   load_use                 : load-use hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    logic rs1Match;
    logic rs2Match;

    assign rs1Match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2Match = id_uses_rs2 && (id_rs2 == ex_rd);

    // A load into x0 produces nothing the ID instruction could depend on.
    assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1Match || rs2Match);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Drives the load
// enables and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers, resolving memory-wait stalls, taken branches and load-use
// hazards (in that priority order). Tracks memory-wait episodes and raises a
// sticky timeout flag when a wait reaches MEM_TIMEOUT cycles.
//
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles and
// flush_count performance counters (and the CNT_W parameter).
//
// Ports:
//   clock, reset                : rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs*   : ID-stage source operands
//   ex_rd, ex_mem_read          : EX-stage destination / load flag
//   ex_branch_taken             : taken branch/jump resolved in EX
//   mem_req, mem_ready          : data-memory handshake from MEM
//   *_en                        : pipeline register load enables
//   if_id_flush, id_ex_flush    : load a bubble into IF/ID, ID/EX
//   mem_wb_bubble               : MEM/WB loads a no-write bubble
//   stalled                     : PC is frozen this cycle
//   mem_timeout                 : sticky memory-wait timeout flag
//   stall_cycles, flush_count   : performance counters (PIPE_CTRL_PERF_EN)
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  stalled,
    output logic                  mem_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
`endif
);

    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    state_e            state_q,       state_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic loadUse;
    logic memStall;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (loadUse)
    );

    // In RUN a stall needs an outstanding request; once waiting, the MEM
    // stage stays frozen until the memory reports completion, so mem_req is
    // no longer consulted.
    assign memStall = (state_q == RUN) ? (mem_req && !mem_ready) : !mem_ready;

    // State, wait counter and sticky timeout registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state and Mealy output decode. The release cycle of a memory wait
    // falls through to the branch / load-use checks, so a hazard frozen
    // during the wait takes effect on that same cycle.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        if (reset) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (memStall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end
            if (wait_cnt_d == WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (loadUse) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign stalled     = ~pc_en;
    assign mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;

    // Free-running performance counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_en) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (if_id_flush) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Every cycle it drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard sources:

- load-use data hazards,
- taken branches resolved in EX,
- multi-cycle data-memory accesses via a req/ready handshake.

A small FSM tracks memory-wait episodes and a sticky timeout.

## Interface

Parameters:

- MEM_TIMEOUT, 16: memory-wait cycle count at which mem_timeout is raised (≥2).
- CNT_W, 32: width of performance counters (PIPE_CTRL_PERF_EN only).

Ports:

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset. One clock; the reset is synchronous and active-high.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_rd  in  5  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- mem_req  in  1  MEM stage accessing data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables.
- if_id_flush, id_ex_flush  out  1  load a bubble (zero control) next edge.
- mem_wb_bubble  out  1  MEM/WB loads reg_write=0, mem_to_reg=0.
- stalled  out  1  high whenever pc_en=0.
- mem_timeout  out  1  sticky error flag.
- stall_cycles, flush_count  out  CNT_W  performance counters (PIPE_CTRL_PERF_EN only).

## Operation

**FSM states:** RUN, MEM_WAIT.

- RUN → MEM_WAIT when mem_req=1 and mem_ready=0.
- MEM_WAIT → RUN on the cycle mem_ready=1.

**Priority in RUN** (highest first):

1. **Memory stall** (mem_req & !mem_ready):
   - pc_en, if_id_en, id_ex_en, ex_mem_en = 0.
   - mem_wb_en = 1, mem_wb_bubble = 1.
   - All flushes 0.
2. **Branch** (ex_branch_taken):
   - All enables 1.
   - if_id_flush = id_ex_flush = 1.
3. **Load-use**, i.e. ex_mem_read & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)):
   - pc_en = if_id_en = 0.
   - id_ex_en = 1, id_ex_flush = 1.
   - ex_mem_en = mem_wb_en = 1.
4. **Otherwise:** all enables 1, flushes 0, mem_wb_bubble 0.

**MEM_WAIT:**

- While mem_ready=0: same outputs as a memory stall.
- On the mem_ready=1 cycle: outputs are evaluated exactly as in RUN, with the memory-stall term forced false.
- Consequence: a branch or load-use frozen in EX/ID during the wait is applied on the release cycle.

**Timeout:**

- wait_cnt counts stall cycles. The RUN→MEM_WAIT cycle counts as 1.
- wait_cnt saturates at MEM_TIMEOUT.
- mem_timeout sets on the edge at which wait_cnt reaches MEM_TIMEOUT.
- The FSM keeps waiting after timeout; mem_timeout clears only on reset.
- wait_cnt clears on the release cycle.

**Load-use note:** a load-use stall lasts exactly one cycle, because the load advances to MEM and the compare then fails. This needs no state.

## Timing

- All enable, flush and bubble outputs are combinational (Mealy) from state and inputs. Zero-cycle latency: they take effect on the same rising edge.
- Registered: state, wait_cnt, mem_timeout, counters.

**While reset=1:**

- All five enables = 0; flushes and mem_wb_bubble = 0; stalled = 1.
- On the edge: state←RUN, wait_cnt←0, mem_timeout←0, counters←0.

**Reset during MEM_WAIT:** returns to RUN next edge, with no residual stall.

**Boundary cases:**

- mem_req and mem_ready both 1 in RUN: no stall, no state change.
- Branch and load-use together: the branch wins; the dependent ID instruction is flushed, not stalled.
- ex_rd=0 never causes a load-use stall.

## Configuration

- **PIPE_CTRL_PERF_EN defined:**
  - stall_cycles increments every non-reset cycle with pc_en=0.
  - flush_count increments every cycle with if_id_flush=1.
  - Both wrap modulo 2^CNT_W.
- **Undefined:** the counter ports and logic are absent, and the module has no such outputs.

## Structure

- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT),
  - REG_ADDR_W=5,
  - the x0 register-index constant.
- One natural sub-module, hazard_detect: purely combinational, producing the load-use compare (load_use output).
- The FSM, timeout counter and output decode stay in pipeline_ctrl.

## Test plan

- **Load-use:** ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; all enables 1 the next cycle.
- **Branch:** ex_branch_taken=1 with no hazard → if_id_flush=id_ex_flush=1, pc_en=1; flush_count +1 with PIPE_CTRL_PERF_EN.
- **Memory wait:** mem_req=1, mem_ready low for 3 cycles, then high → 3 cycles of all upstream enables 0 and mem_wb_bubble=1; the 4th cycle has all enables 1; stall_cycles=3.
- **Timeout:** MEM_TIMEOUT=4, mem_ready held low 6 cycles → mem_timeout rises after the 4th stall edge and stays 1 after mem_ready; it clears only after reset.
- **Simultaneous events:** load-use and branch together → branch behaviour only. Separately, branch asserted during MEM_WAIT → flushes appear only on the mem_ready cycle.
- **Reset:** reset mid-MEM_WAIT → next cycle in RUN with all enables 1; mem_timeout=0 and counters=0.
